// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that serialises per-requester cache operations onto a
// single controller port, with per-operation timeout and a sticky error flag.
package ctrl_types_pkg;
    typedef enum logic [1:0] {
        NOOP   = 2'd0,
        READ   = 2'd1,
        UPSERT = 2'd2,
        DELETE = 2'd3
    } operation_e;
endpackage

module cache_req_arbiter
    import ctrl_types_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  operation_e                 req_op [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic                       resp_succ,
    output logic                       resp_timeout,
    output operation_e                 ctrl_op,
    input  logic                       ctrl_rdy,
    input  logic                       ctrl_succ,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_sticky
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state, state_nxt;
    logic [GW-1:0] rr_ptr, grant_q, winner;
    operation_e    op_q, winner_op;
    logic [CW-1:0] cnt;
    logic          found, succ_q, to_q, err_q, timeout_hit;
    int            scan_idx;

    // Scan upward from rr_ptr with wrap; the first eligible requester wins.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        winner_op = NOOP;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[scan_idx] && req_op[scan_idx] != NOOP) begin
                found     = 1'b1;
                winner    = GW'(scan_idx);
                winner_op = req_op[scan_idx];
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ctrl_rdy || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            op_q    <= NOOP;
            cnt     <= '0;
            succ_q  <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= winner;
                        op_q    <= winner_op;
                        rr_ptr  <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + GW'(1);
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // ctrl_rdy takes priority over a coincident timeout.
                    if (ctrl_rdy) begin
                        succ_q <= ctrl_succ;
                        to_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        succ_q <= 1'b0;
                        to_q   <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state so reset clears them immediately.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state == ISSUE) req_ready[grant_q]  = 1'b1;
        if (state == RESP)  resp_valid[grant_q] = 1'b1;
    end

    assign ctrl_op      = (state == ISSUE) ? op_q : NOOP;
    assign resp_succ    = (state == RESP) && succ_q;
    assign resp_timeout = (state == RESP) && to_q;
    assign grant_id     = grant_q;
    assign busy         = (state != IDLE);
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8).
module tb_cache_req_arbiter;
    import ctrl_types_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    operation_e req_op [4];
    logic [3:0] req_ready, resp_valid;
    logic       resp_succ, resp_timeout, ctrl_rdy, ctrl_succ, busy, err_sticky;
    operation_e ctrl_op;
    logic [1:0] grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    cache_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_succ(resp_succ),
        .resp_timeout(resp_timeout), .ctrl_op(ctrl_op), .ctrl_rdy(ctrl_rdy),
        .ctrl_succ(ctrl_succ), .grant_id(grant_id), .busy(busy), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        for (int i = 0; i < 4; i++) req_op[i] = NOOP;
        ctrl_rdy  = 1'b0;
        ctrl_succ = 1'b0;
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (ctrl_op !== NOOP) begin n_bad++; $display("FAIL reset_ctrl_op: got %0d want 0", ctrl_op); end
        n_cmp++; if (req_ready !== 4'b0 || resp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_handshake: got rdy=%b rv=%b want 0000/0000", req_ready, resp_valid); end
        n_cmp++; if (grant_id !== 2'd0 || err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_regs: got gid=%0d err=%0b want 0/0", grant_id, err_sticky); end
        ctrl_rdy = 1'b1;  // ignored while IDLE with no requests
        tick();
        ctrl_rdy = 1'b0;
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 4'b0) begin n_bad++; $display("FAIL idle_rdy_ignored: got busy=%0b rv=%b want 0/0000", busy, resp_valid); end
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_op[2] = READ;
        tick();  // ISSUE
        n_cmp++; if (ctrl_op !== READ) begin n_bad++; $display("FAIL single_ctrl_op: got %0d want %0d", ctrl_op, READ); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
        n_cmp++; if (grant_id !== 2'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL single_grant: got gid=%0d busy=%0b want 2/1", grant_id, busy); end
        req_valid = 4'b0000;  // drop after acceptance, and disturb the op
        req_op[2] = DELETE;
        tick();  // WAIT
        n_cmp++; if (ctrl_op !== NOOP || req_ready !== 4'b0) begin n_bad++; $display("FAIL single_wait_quiet: got op=%0d rdy=%b want 0/0000", ctrl_op, req_ready); end
        ctrl_rdy  = 1'b1;
        ctrl_succ = 1'b1;
        tick();  // RESP
        ctrl_rdy  = 1'b0;
        ctrl_succ = 1'b0;
        n_cmp++; if (resp_valid !== 4'b0100 || resp_succ !== 1'b1 || resp_timeout !== 1'b0) begin n_bad++; $display("FAIL single_resp: got rv=%b s=%0b t=%0b want 0100/1/0", resp_valid, resp_succ, resp_timeout); end
        tick();  // IDLE
        n_cmp++; if (resp_valid !== 4'b0 || resp_succ !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_after: got rv=%b s=%0b busy=%0b want 0000/0/0", resp_valid, resp_succ, busy); end
        req_op[2] = NOOP;
    endtask

    task automatic test_round_robin();
        operation_e ops [4];
        int order [5];
        logic [3:0] onehot;
        ops   = '{READ, UPSERT, DELETE, READ};
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) req_op[i] = ops[i];
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            onehot = 4'b0001 << order[k];
            tick();  // ISSUE
            n_cmp++; if (grant_id !== 2'(order[k]) || ctrl_op !== ops[order[k]] || req_ready !== onehot) begin
                n_bad++; $display("FAIL rr_issue_%0d: got gid=%0d op=%0d rdy=%b want %0d/%0d/%b", k, grant_id, ctrl_op, req_ready, order[k], ops[order[k]], onehot); end
            tick();  // WAIT
            n_cmp++; if (ctrl_op !== NOOP) begin n_bad++; $display("FAIL rr_noop_%0d: got %0d want 0", k, ctrl_op); end
            ctrl_rdy  = 1'b1;
            ctrl_succ = k[0];
            tick();  // RESP
            ctrl_rdy  = 1'b0;
            n_cmp++; if (resp_valid !== onehot || resp_succ !== k[0]) begin
                n_bad++; $display("FAIL rr_resp_%0d: got rv=%b s=%0b want %b/%0b", k, resp_valid, resp_succ, onehot, k[0]); end
            tick();  // IDLE (grant decided at the next edge)
        end
        req_valid = 4'b0;
        ctrl_succ = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        req_valid = 4'b0010;
        req_op[1] = UPSERT;
        tick();  // ISSUE
        n_cmp++; if (grant_id !== 2'd1 || ctrl_op !== UPSERT) begin n_bad++; $display("FAIL to_issue: got gid=%0d op=%0d want 1/%0d", grant_id, ctrl_op, UPSERT); end
        req_valid = 4'b0;
        tick();  // first WAIT cycle
        for (int i = 1; i < 8; i++) begin
            tick();
            n_cmp++; if (resp_valid !== 4'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_wait_%0d: got rv=%b busy=%0b want 0000/1", i, resp_valid, busy); end
        end
        tick();  // RESP, 8 cycles after entering WAIT
        n_cmp++; if (resp_valid !== 4'b0010 || resp_succ !== 1'b0 || resp_timeout !== 1'b1 || err_sticky !== 1'b1) begin
            n_bad++; $display("FAIL to_resp: got rv=%b s=%0b t=%0b err=%0b want 0010/0/1/1", resp_valid, resp_succ, resp_timeout, err_sticky); end
        tick();
        tick();
        n_cmp++; if (err_sticky !== 1'b1 || resp_timeout !== 1'b0) begin n_bad++; $display("FAIL to_sticky: got err=%0b t=%0b want 1/0", err_sticky, resp_timeout); end
    endtask

    task automatic test_boundary();
        do_reset();
        n_cmp++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %0b want 0", err_sticky); end
        req_valid = 4'b0011;
        req_op[0] = NOOP;
        req_op[1] = DELETE;
        tick();  // ISSUE
        n_cmp++; if (grant_id !== 2'd1 || req_ready !== 4'b0010 || ctrl_op !== DELETE) begin
            n_bad++; $display("FAIL bnd_issue: got gid=%0d rdy=%b op=%0d want 1/0010/%0d", grant_id, req_ready, ctrl_op, DELETE); end
        req_valid = 4'b0;
        tick();  // first WAIT cycle
        repeat (7) tick();  // now on the last timeout cycle
        ctrl_rdy  = 1'b1;
        ctrl_succ = 1'b1;
        tick();  // RESP
        ctrl_rdy  = 1'b0;
        ctrl_succ = 1'b0;
        n_cmp++; if (resp_valid !== 4'b0010 || resp_succ !== 1'b1 || resp_timeout !== 1'b0 || err_sticky !== 1'b0) begin
            n_bad++; $display("FAIL bnd_resp: got rv=%b s=%0b t=%0b err=%0b want 0010/1/0/0", resp_valid, resp_succ, resp_timeout, err_sticky); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 4'b0100;
        req_op[2] = READ;
        tick();  // ISSUE
        req_valid = 4'b0;
        tick();  // WAIT
        tick();  // WAIT
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 4'b0 || ctrl_op !== NOOP || grant_id !== 2'd0) begin
            n_bad++; $display("FAIL rst_async: got busy=%0b rv=%b op=%0d gid=%0d want 0/0000/0/0", busy, resp_valid, ctrl_op, grant_id); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_no_resp: got rv=%b busy=%0b want 0000/0", resp_valid, busy); end
        req_valid = 4'b1000;
        req_op[3] = UPSERT;
        tick();  // ISSUE
        n_cmp++; if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin n_bad++; $display("FAIL rst_grant3: got gid=%0d rdy=%b want 3/1000", grant_id, req_ready); end
        req_valid = 4'b0;
        tick();
        ctrl_rdy = 1'b1;
        tick();
        ctrl_rdy = 1'b0;
        tick();
        // rr_ptr restarts at 0 after reset: requester 1 beats requester 3.
        do_reset();
        req_valid = 4'b1010;
        req_op[1] = READ;
        tick();
        n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL rst_rr_ptr: got gid=%0d want 1", grant_id); end
        req_valid = 4'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_boundary();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
